// File: rtl/sram_arbiter.sv
// Two-requester valid/ready arbiter in front of a fixed-latency SRAM controller; routes read data back by issuer.
// Round-robin by default; define SRAM_ARB_PRIORITY_EN for m0 priority with an m1 starvation limit.
module sram_arbiter #(
  parameter int ADDR_BITS    = 20,
  parameter int DATA_BITS    = 16,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [DATA_BITS-1:0] m0_wdata,
  output logic                 m0_ready,
  output logic                 m0_rd_valid,
  output logic [DATA_BITS-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [DATA_BITS-1:0] m1_wdata,
  output logic                 m1_ready,
  output logic                 m1_rd_valid,
  output logic [DATA_BITS-1:0] m1_rdata,
  output logic                 sram_req,
  output logic                 sram_write_enable,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_write_data,
  input  logic                 sram_ready,
  input  logic [DATA_BITS-1:0] sram_read_data
);

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("sram_arbiter: RD_LATENCY must be at least 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("sram_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic                  grant_id;
  logic                  fire;
  logic                  rd_fire;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_id;

`ifdef SRAM_ARB_PRIORITY_EN
  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  logic [CNT_BITS-1:0] starve_cnt;

  // m1 only wins a tie once m0 has used up its allowance of consecutive grants.
  assign grant_id = m1_req & (~m0_req | (starve_cnt == CNT_BITS'(STARVE_LIMIT)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!m1_req || (fire && grant_id)) begin
      starve_cnt <= '0;
    end else if (fire && starve_cnt != CNT_BITS'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic last_grant;

  assign grant_id = m1_req & (~m0_req | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (fire) begin
      last_grant <= grant_id;
    end
  end
`endif

  assign sram_req = m0_req | m1_req;
  assign fire     = sram_req & sram_ready;
  assign m0_ready = m0_req & ~grant_id & sram_ready;
  assign m1_ready = grant_id & sram_ready;
  assign rd_fire  = fire & ~sram_write_enable;

  always_comb begin
    sram_write_enable = 1'b0;
    sram_addr         = '0;
    sram_write_data   = '0;
    if (sram_req) begin
      sram_write_enable = grant_id ? m1_we    : m0_we;
      sram_addr         = grant_id ? m1_addr  : m0_addr;
      sram_write_data   = grant_id ? m1_wdata : m0_wdata;
    end
  end

  // Tracks which requester owns each read in the controller pipeline; free-running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= rd_fire;
      pipe_id[0]  <= grant_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      m0_rd_valid <= pipe_vld[RD_LATENCY-1] & ~pipe_id[RD_LATENCY-1];
      m1_rd_valid <= pipe_vld[RD_LATENCY-1] & pipe_id[RD_LATENCY-1];
      if (pipe_vld[RD_LATENCY-1] && !pipe_id[RD_LATENCY-1]) m0_rdata <= sram_read_data;
      if (pipe_vld[RD_LATENCY-1] && pipe_id[RD_LATENCY-1])  m1_rdata <= sram_read_data;
    end
  end

endmodule
